spike_fifo_arbiter: RTL and testbench
=====================================

// Module: spike_fifo_arbiter
// PURPOSE
//  Shares the write port of the 16-entry, 4-bit spike-event FIFO among N neurons.
//  Latches single-cycle spike pulses and grants pending neurons round-robin, one per cycle.
//  Writes each granted neuron ID into the FIFO and tracks occupancy so no write is issued when full.
//  Sits between the neuron array and the FIFO; the downstream consumer drives fifo_ren directly.
// PARAMETERS
//  N_NEURONS  16  number of requesting neurons (2..2**ID_W)
//  ID_W       4   neuron ID width = FIFO data width
//  DEPTH      16  FIFO capacity in entries
//  CNT_W      8   width of saturating lost-spike counter
// PORTS
//  clock       in   1          rising-edge clock
//  reset       in   1          synchronous, active-high reset
//  enable      in   1          1 = grants allowed; 0 = hold (pending still accumulate)
//  spike_in    in   N_NEURONS  per-neuron spike pulse, sampled every edge
//  fifo_ren    in   1          consumer read strobe (same signal driving the FIFO)
//  fifo_wen    out  1          registered FIFO write enable
//  fifo_din    out  ID_W       registered neuron ID, valid when fifo_wen=1
//  pending     out  N_NEURONS  latched-not-yet-written spikes
//  count       out  $clog2(DEPTH+1)  FIFO occupancy
//  full        out  1          count == DEPTH
//  busy        out  1          state != IDLE
//  lost_count  out  CNT_W      saturating count of dropped (merged) spikes
// BEHAVIOUR
//  Reset (sync): pending=0, fifo_wen=0, fifo_din=0, count=0, full=0, rr_ptr=0, lost_count=0, state=IDLE.
//  Pending update per edge: pending[i] <= (pending[i] & ~gnt[i]) | spike_in[i].
//   - spike_in[i]=1 with pending[i]=1 and gnt[i]=0 -> spike merged; lost_count+1 (saturate at all-ones).
//   - spike_in[i]=1 in same cycle gnt[i]=1 -> stays pending, not lost.
//   - multiple losses in one cycle add their popcount (saturating).
//  Arbitration (combinational on registered pending): search i = rr_ptr, rr_ptr+1, ... wrapping at
//   N_NEURONS; first pending i wins. gnt is one-hot or zero.
//  avail = DEPTH - count - fifo_wen (reads in flight ignored; conservative).
//  Grant issued iff enable=1, pending!=0, avail>0. On grant at edge:
//   fifo_wen<=1, fifo_din<=i, pending[i] cleared, rr_ptr<=(i+1) mod N_NEURONS. Else fifo_wen<=0, fifo_din holds.
//  Latency: spike_in sampled at edge E0 -> pending at E0 -> fifo_wen=1 during cycle after E1 -> FIFO writes at E2.
//  Throughput: one write per cycle while avail>0.
//  Occupancy: count <= count + fifo_wen - (fifo_ren && (count>0 || fifo_wen)); never exceeds DEPTH.
//   Simultaneous write+read leaves count unchanged. fifo_ren at count=0 with no write is ignored.
//  full is combinational from count.
//  FSM (registered):
//   IDLE:  pending==0. -> GRANT when pending!=0 and enable and avail>0; -> STALL when pending!=0 otherwise.
//   GRANT: issuing writes. -> IDLE when pending (next) ==0; -> STALL when enable=0 or avail==0.
//   STALL: pending waiting (full or disabled). -> GRANT when enable and avail>0; -> IDLE if pending==0.
//  Reset mid-operation: pending spikes and in-flight write discarded, count zeroed (FIFO must share reset).
//  N_NEURONS < 2**ID_W: IDs above N_NEURONS-1 never emitted.
// TESTING
//  1 Reset, single pulse spike_in[5] -> exactly one fifo_wen cycle with fifo_din=5, 2 edges after sample; count=1.
//  2 Pulses on 3,7,12 same cycle, rr_ptr=0 -> writes 3,7,12 on consecutive cycles; then pulse on 2 and 14 -> 14 then 2.
//  3 All 16 neurons pulse, fifo_ren=0 -> 16 writes, count=16, full=1, busy=1, no 17th write;
//    pulse spike_in[0] again -> stays pending; one fifo_ren -> count 15, exactly one more write of 0.
//  4 spike_in[9] on two consecutive cycles while enable=0 -> lost_count=1, single write of 9 after enable=1.
//  5 Steady read+write each cycle at count=8 -> count stays 8; fifo_ren at count=0 -> count stays 0.
//  6 Assert reset with 5 pending and fifo_wen=1 -> next cycle pending=0, fifo_wen=0, count=0, state IDLE.

Source files
------------

// File: rtl/spike_fifo_arbiter.sv
// spike_fifo_arbiter
//   Shares the write port of a DEPTH-entry spike-event FIFO among N_NEURONS
//   neurons. Single-cycle spike pulses are latched into a pending vector, one
//   pending neuron per cycle is granted in round-robin order, and its ID is
//   written into the FIFO. Occupancy is tracked locally so that a write is
//   never issued into a full FIFO.
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high reset (the FIFO must share it)
//   enable      1 = grants allowed, 0 = hold (spikes still accumulate)
//   spike_in    per-neuron spike pulses, sampled every edge
//   fifo_ren    consumer read strobe, same signal that drives the FIFO
//   fifo_wen    registered FIFO write enable
//   fifo_din    registered neuron ID, valid while fifo_wen = 1
//   pending     latched spikes not yet written
//   count       FIFO occupancy
//   full        count == DEPTH
//   busy        arbiter FSM is not IDLE
//   lost_count  saturating count of spikes merged into an already pending one
module spike_fifo_arbiter #(
  parameter int N_NEURONS = 16,
  parameter int ID_W      = 4,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [N_NEURONS-1:0]         spike_in,
  input  logic                         fifo_ren,
  output logic                         fifo_wen,
  output logic [ID_W-1:0]              fifo_din,
  output logic [N_NEURONS-1:0]         pending,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         busy,
  output logic [CNT_W-1:0]             lost_count
);

  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       next_ptr;
  logic [N_NEURONS-1:0]  gnt;
  logic [ID_W-1:0]       gnt_id;
  logic                  found;
  logic                  can_write;
  logic                  grant_ok;
  logic [N_NEURONS-1:0]  gnt_eff;
  logic [N_NEURONS-1:0]  pending_next;
  logic [N_NEURONS-1:0]  lost_vec;
  logic [CNT_W-1:0]      lost_next;
  logic                  rd_ok;
  logic [CW-1:0]         count_next;

  // Number of set bits in a pending-sized vector.
  function automatic int popcount(input logic [N_NEURONS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < N_NEURONS; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

  // Round-robin search starting at rr_ptr; first pending neuron wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int k = 0; k < N_NEURONS; k++) begin
      if (!found && pending[(int'(rr_ptr) + k) % N_NEURONS]) begin
        found  = 1'b1;
        gnt_id = ID_W'((int'(rr_ptr) + k) % N_NEURONS);
        gnt[(int'(rr_ptr) + k) % N_NEURONS] = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Grant qualification, pending/lost bookkeeping and occupancy arithmetic.
  // The write already in flight is counted as occupying a slot; reads in
  // flight are not credited, so the space estimate is conservative.
  always_comb begin
    can_write    = (int'(count) + int'(fifo_wen)) < DEPTH;
    grant_ok     = enable && found && can_write;
    gnt_eff      = grant_ok ? gnt : '0;
    pending_next = (pending & ~gnt_eff) | spike_in;
    lost_vec     = spike_in & pending & ~gnt_eff;
    if ((int'(lost_count) + popcount(lost_vec)) > ((2 ** CNT_W) - 1)) begin
      lost_next = '1;
    end else begin
      lost_next = CNT_W'(int'(lost_count) + popcount(lost_vec));
    end
    rd_ok      = fifo_ren && ((count != '0) || fifo_wen);
    count_next = count + CW'(fifo_wen) - CW'(rd_ok);
    if (int'(gnt_id) == N_NEURONS - 1) begin
      next_ptr = '0;
    end else begin
      next_ptr = gnt_id + 1'b1;
    end
  end

  // Next-state logic of the arbiter FSM.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pending != '0) begin
          state_next = grant_ok ? GRANT : STALL;
        end else begin
          state_next = IDLE;
        end
      end
      GRANT: begin
        if (pending_next == '0) begin
          state_next = IDLE;
        end else if (!enable || !can_write) begin
          state_next = STALL;
        end else begin
          state_next = GRANT;
        end
      end
      STALL: begin
        if (pending == '0) begin
          state_next = IDLE;
        end else if (grant_ok) begin
          state_next = GRANT;
        end else begin
          state_next = STALL;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, pending vector, write port, pointer and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      fifo_wen   <= 1'b0;
      fifo_din   <= '0;
      rr_ptr     <= '0;
      count      <= '0;
      lost_count <= '0;
    end else begin
      state      <= state_next;
      pending    <= pending_next;
      fifo_wen   <= grant_ok;
      count      <= count_next;
      lost_count <= lost_next;
      if (grant_ok) begin
        fifo_din <= gnt_id;
        rr_ptr   <= next_ptr;
      end else begin
        fifo_din <= fifo_din;
        rr_ptr   <= rr_ptr;
      end
    end
  end

  assign full = (count == CW'(DEPTH));
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_spike_fifo_arbiter.sv
module tb_spike_fifo_arbiter;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [15:0] spike_in;
  logic        fifo_ren;
  logic        fifo_wen;
  logic [3:0]  fifo_din;
  logic [15:0] pending;
  logic [4:0]  count;
  logic        full;
  logic        busy;
  logic [7:0]  lost_count;

  int errors = 0;
  int checks = 0;
  int wr_seen = 0;
  logic [3:0] exp_q[$];

  spike_fifo_arbiter dut (
    .clock(clock), .reset(reset), .enable(enable), .spike_in(spike_in),
    .fifo_ren(fifo_ren), .fifo_wen(fifo_wen), .fifo_din(fifo_din),
    .pending(pending), .count(count), .full(full), .busy(busy),
    .lost_count(lost_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard: every write seen on the FIFO port must match the next expected ID
  always @(negedge clock) begin
    logic [3:0] e;
    if (fifo_wen === 1'b1) begin
      wr_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got id %0d, no write expected", fifo_din);
      end else begin
        e = exp_q.pop_front();
        if (fifo_din !== e) begin
          errors++;
          $display("FAIL write_id: got %0d expected %0d", fifo_din, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; enable = 1'b1; spike_in = 16'h0000; fifo_ren = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: %0d expected writes missing, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({fifo_wen, fifo_din, pending, count, full, busy, lost_count} !== 40'd0) begin
      errors++;
      $display("FAIL reset_state: wen=%0d din=%0d pend=%h cnt=%0d full=%0d busy=%0d lost=%0d, required all 0",
               fifo_wen, fifo_din, pending, count, full, busy, lost_count);
    end
  endtask

  task automatic test_single_pulse();
    apply_reset();
    spike_in = 16'h0020; exp_q.push_back(4'd5);
    step();
    spike_in = 16'h0000;
    checks++;
    if (fifo_wen !== 1'b0 || pending !== 16'h0020) begin
      errors++;
      $display("FAIL single_e0: wen=%0d pend=%h, required wen=0 pend=0020", fifo_wen, pending);
    end
    step();
    checks++;
    if (fifo_wen !== 1'b1 || fifo_din !== 4'd5) begin
      errors++;
      $display("FAIL single_e1: wen=%0d din=%0d, required wen=1 din=5", fifo_wen, fifo_din);
    end
    step();
    checks++;
    if (fifo_wen !== 1'b0 || count !== 5'd1) begin
      errors++;
      $display("FAIL single_e2: wen=%0d cnt=%0d, required wen=0 cnt=1", fifo_wen, count);
    end
    step(); step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%0d required 0", busy);
    end
    check_drained("single");
  endtask

  task automatic test_round_robin();
    logic [3:0] ids[3] = '{4'd3, 4'd7, 4'd12};
    apply_reset();
    spike_in = 16'h1088;
    foreach (ids[i]) exp_q.push_back(ids[i]);
    step();
    spike_in = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (fifo_wen !== 1'b1 || fifo_din !== ids[i]) begin
        errors++;
        $display("FAIL rr_consecutive[%0d]: wen=%0d din=%0d, required wen=1 din=%0d", i, fifo_wen, fifo_din, ids[i]);
      end
    end
    repeat (3) step();
    spike_in = 16'h4004; exp_q.push_back(4'd14); exp_q.push_back(4'd2);
    step();
    spike_in = 16'h0000;
    repeat (5) step();
    checks++;
    if (count !== 5'd5) begin
      errors++;
      $display("FAIL rr_count: got %0d required 5", count);
    end
    check_drained("rr");
  endtask

  task automatic test_full();
    int base;
    apply_reset();
    base = wr_seen;
    spike_in = 16'hFFFF;
    for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
    step();
    spike_in = 16'h0000;
    repeat (20) step();
    checks++;
    if (count !== 5'd16 || full !== 1'b1 || wr_seen - base != 16) begin
      errors++;
      $display("FAIL full_fill: cnt=%0d full=%0d writes=%0d, required 16/1/16", count, full, wr_seen - base);
    end
    spike_in = 16'h0001;
    step();
    spike_in = 16'h0000;
    repeat (3) step();
    checks++;
    if (pending !== 16'h0001 || busy !== 1'b1 || fifo_wen !== 1'b0 || wr_seen - base != 16) begin
      errors++;
      $display("FAIL full_hold: pend=%h busy=%0d wen=%0d writes=%0d, required 0001/1/0/16",
               pending, busy, fifo_wen, wr_seen - base);
    end
    exp_q.push_back(4'd0);
    fifo_ren = 1'b1;
    step();
    fifo_ren = 1'b0;
    checks++;
    if (count !== 5'd15 || full !== 1'b0) begin
      errors++;
      $display("FAIL full_read: cnt=%0d full=%0d, required 15/0", count, full);
    end
    repeat (4) step();
    checks++;
    if (count !== 5'd16 || wr_seen - base != 17 || pending !== 16'h0000) begin
      errors++;
      $display("FAIL full_refill: cnt=%0d writes=%0d pend=%h, required 16/17/0000", count, wr_seen - base, pending);
    end
    check_drained("full");
  endtask

  task automatic test_lost_spike();
    apply_reset();
    enable = 1'b0;
    spike_in = 16'h0200;
    step(); step();
    spike_in = 16'h0000;
    checks++;
    if (lost_count !== 8'd1 || pending !== 16'h0200) begin
      errors++;
      $display("FAIL lost_merge: lost=%0d pend=%h, required 1/0200", lost_count, pending);
    end
    repeat (3) step();
    checks++;
    if (busy !== 1'b1 || fifo_wen !== 1'b0) begin
      errors++;
      $display("FAIL lost_hold: busy=%0d wen=%0d, required 1/0", busy, fifo_wen);
    end
    exp_q.push_back(4'd9);
    enable = 1'b1;
    repeat (4) step();
    checks++;
    if (count !== 5'd1 || lost_count !== 8'd1) begin
      errors++;
      $display("FAIL lost_release: cnt=%0d lost=%0d, required 1/1", count, lost_count);
    end
    check_drained("lost");
  endtask

  task automatic test_back_to_back();
    int t;
    apply_reset();
    spike_in = 16'h00FF;
    for (int i = 0; i < 8; i++) exp_q.push_back(4'(i));
    step();
    spike_in = 16'h0000;
    repeat (12) step();
    checks++;
    if (count !== 5'd8) begin
      errors++;
      $display("FAIL b2b_prefill: cnt=%0d required 8", count);
    end
    spike_in = 16'hFF00;
    for (int i = 8; i < 16; i++) exp_q.push_back(4'(i));
    step();
    spike_in = 16'h0000;
    t = 0;
    @(negedge clock);
    while (fifo_wen !== 1'b1 && t < 10) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (fifo_wen !== 1'b1) begin
      errors++;
      $display("FAIL b2b_timeout: wen=%0d after %0d cycles, required 1", fifo_wen, t);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (count !== 5'd8 || fifo_wen !== 1'b1) begin
        errors++;
        $display("FAIL b2b_steady[%0d]: cnt=%0d wen=%0d, required 8/1", i, count, fifo_wen);
      end
      fifo_ren = 1'b1;
      @(negedge clock);
    end
    fifo_ren = 1'b0;
    checks++;
    if (count !== 5'd8 || fifo_wen !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: cnt=%0d wen=%0d, required 8/0", count, fifo_wen);
    end
    check_drained("b2b");
    apply_reset();
    fifo_ren = 1'b1;
    step(); step();
    fifo_ren = 1'b0;
    checks++;
    if (count !== 5'd0) begin
      errors++;
      $display("FAIL empty_read: cnt=%0d required 0", count);
    end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    spike_in = 16'h003F; exp_q.push_back(4'd0);
    step();
    spike_in = 16'h0000;
    step();
    checks++;
    if (fifo_wen !== 1'b1 || pending !== 16'h003E) begin
      errors++;
      $display("FAIL midop_pre: wen=%0d pend=%h, required 1/003E", fifo_wen, pending);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (pending !== 16'h0000 || fifo_wen !== 1'b0 || count !== 5'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: pend=%h wen=%0d cnt=%0d busy=%0d, required 0/0/0/0",
               pending, fifo_wen, count, busy);
    end
    repeat (3) step();
    check_drained("midop");
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; spike_in = 16'h0000; fifo_ren = 1'b0;
    test_reset();
    test_single_pulse();
    test_round_robin();
    test_full();
    test_lost_spike();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
